ts_sync_lock: RTL and testbench



---
 rtl/ts_pkg.sv | 16 +
 rtl/ts_sync_lock_if.sv | 22 ++
 rtl/ts_sync_lock.sv | 188 ++++++++++++++++++
 tb/tb_ts_sync_lock.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_pkg.sv
// Shared TS framing constants and framer state encoding.
package ts_pkg;

   localparam int unsigned PACK_BYTE_SIZE = 188;
   localparam logic [7:0]  TS_SYNC_BYTE   = 8'h47;

   localparam int unsigned POS_W = 8;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCK   = 2'd2
   } ts_state_e;

endpackage

// File: rtl/ts_sync_lock_if.sv
// Raw byte input and framed byte output of the TS sync framer.
// master: stream source / framed-stream consumer; slave: the framer.
interface ts_sync_lock_if;

   logic [7:0] in_data;
   logic       in_valid;
   logic       locked;
   logic [7:0] mpeg_data;
   logic       mpeg_valid;
   logic       mpeg_sync;

   modport master (
      output in_data, in_valid,
      input  locked, mpeg_data, mpeg_valid, mpeg_sync
   );

   modport slave (
      input  in_data, in_valid,
      output locked, mpeg_data, mpeg_valid, mpeg_sync
   );

endinterface

// File: rtl/ts_sync_lock.sv
// TS sync framer: hunts for the sync byte, verifies packet spacing,
// then emits a framed stream with mpeg_sync on byte 0 of each packet.
// Flywheels through isolated sync misses; drops lock after UNLOCK_COUNT.
// Optional statistics counters are enabled with TS_SYNC_STATS_EN.
module ts_sync_lock
   import ts_pkg::*;
#(
   parameter int unsigned LOCK_COUNT         = 3,
   parameter int unsigned UNLOCK_COUNT       = 3,
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32
) (
   input  logic clk,
   input  logic rst,
   ts_sync_lock_if.slave bus
`ifdef TS_SYNC_STATS_EN
   ,
   output logic [C_S_AXI_DATA_WIDTH-1:0] packet_count,
   output logic [C_S_AXI_DATA_WIDTH-1:0] lock_loss_count
`endif
);

   localparam logic [POS_W-1:0] POS_LAST = POS_W'(PACK_BYTE_SIZE - 1);
   localparam logic [CNT_W-1:0] LOCK_N   = CNT_W'(LOCK_COUNT);
   localparam logic [CNT_W-1:0] UNLOCK_N = CNT_W'(UNLOCK_COUNT);

   ts_state_e        state, state_nxt;
   logic [POS_W-1:0] pos, pos_nxt;
   logic [CNT_W-1:0] good, good_nxt;
   logic [CNT_W-1:0] miss, miss_nxt;

   logic             emit_c;
   logic             emit_sync_c;
   logic             lost_c;

   logic             slot_c;
   logic             is_sync_c;
   logic [POS_W-1:0] pos_inc_c;
   logic [CNT_W-1:0] good_inc_c;
   logic [CNT_W-1:0] miss_inc_c;

   logic             locked_q;
   logic [7:0]       mpeg_data_q;
   logic             mpeg_valid_q;
   logic             mpeg_sync_q;

   // Framer state and position registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_HUNT;
         pos   <= '0;
         good  <= '0;
         miss  <= '0;
      end else begin
         state <= state_nxt;
         pos   <= pos_nxt;
         good  <= good_nxt;
         miss  <= miss_nxt;
      end
   end

   // Next-state, position bookkeeping and emit decision for the current byte.
   always_comb begin
      state_nxt   = state;
      pos_nxt     = pos;
      good_nxt    = good;
      miss_nxt    = miss;
      emit_c      = 1'b0;
      emit_sync_c = 1'b0;
      lost_c      = 1'b0;

      slot_c     = (pos == '0);
      is_sync_c  = (bus.in_data == TS_SYNC_BYTE);
      pos_inc_c  = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
      good_inc_c = good + CNT_W'(1);
      miss_inc_c = miss + CNT_W'(1);

      if (bus.in_valid) begin
         unique case (state)
            ST_HUNT: begin
               if (is_sync_c) begin
                  pos_nxt  = POS_W'(1);
                  good_nxt = CNT_W'(1);
                  if (LOCK_N == CNT_W'(1)) begin
                     state_nxt   = ST_LOCK;
                     miss_nxt    = '0;
                     emit_c      = 1'b1;
                     emit_sync_c = 1'b1;
                  end else begin
                     state_nxt = ST_VERIFY;
                  end
               end
            end

            ST_VERIFY: begin
               if (!slot_c) begin
                  pos_nxt = pos_inc_c;
               end else if (is_sync_c) begin
                  pos_nxt  = pos_inc_c;
                  good_nxt = good_inc_c;
                  if (good_inc_c == LOCK_N) begin
                     state_nxt   = ST_LOCK;
                     miss_nxt    = '0;
                     emit_c      = 1'b1;
                     emit_sync_c = 1'b1;
                  end
               end else begin
                  // Misaligned candidate: the failing byte is consumed.
                  state_nxt = ST_HUNT;
                  pos_nxt   = '0;
                  good_nxt  = '0;
               end
            end

            ST_LOCK: begin
               if (slot_c && !is_sync_c) begin
                  miss_nxt = miss_inc_c;
                  if (miss_inc_c == UNLOCK_N) begin
                     state_nxt = ST_HUNT;
                     pos_nxt   = '0;
                     good_nxt  = '0;
                     miss_nxt  = '0;
                     lost_c    = 1'b1;
                  end else begin
                     // Flywheel: keep framing on the expected slot.
                     pos_nxt     = pos_inc_c;
                     emit_c      = 1'b1;
                     emit_sync_c = 1'b1;
                  end
               end else begin
                  if (slot_c) begin
                     miss_nxt = '0;
                  end
                  pos_nxt     = pos_inc_c;
                  emit_c      = 1'b1;
                  emit_sync_c = slot_c;
               end
            end

            default: begin
               state_nxt = ST_HUNT;
               pos_nxt   = '0;
               good_nxt  = '0;
               miss_nxt  = '0;
            end
         endcase
      end
   end

   // Registered framed output; data holds while no byte is emitted.
   always_ff @(posedge clk) begin
      if (rst) begin
         locked_q     <= 1'b0;
         mpeg_data_q  <= '0;
         mpeg_valid_q <= 1'b0;
         mpeg_sync_q  <= 1'b0;
      end else begin
         locked_q     <= (state_nxt == ST_LOCK);
         mpeg_valid_q <= emit_c;
         mpeg_sync_q  <= emit_sync_c;
         if (emit_c) begin
            mpeg_data_q <= bus.in_data;
         end
      end
   end

   assign bus.locked     = locked_q;
   assign bus.mpeg_data  = mpeg_data_q;
   assign bus.mpeg_valid = mpeg_valid_q;
   assign bus.mpeg_sync  = mpeg_sync_q;

`ifdef TS_SYNC_STATS_EN
   // Packet-start and lock-loss statistics, wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         packet_count    <= '0;
         lock_loss_count <= '0;
      end else begin
         if (emit_c && emit_sync_c) begin
            packet_count <= packet_count + C_S_AXI_DATA_WIDTH'(1);
         end
         if (lost_c) begin
            lock_loss_count <= lock_loss_count + C_S_AXI_DATA_WIDTH'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_ts_sync_lock.sv
// Directed self-checking bench for the TS sync framer.
module tb_ts_sync_lock;
   import ts_pkg::*;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   ts_sync_lock_if bus ();

`ifdef TS_SYNC_STATS_EN
   logic [31:0] packet_count;
   logic [31:0] lock_loss_count;
`endif

   ts_sync_lock #(
      .LOCK_COUNT         (3),
      .UNLOCK_COUNT       (3),
      .C_S_AXI_DATA_WIDTH (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef TS_SYNC_STATS_EN
      ,
      .packet_count    (packet_count),
      .lock_loss_count (lock_loss_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Payload byte for packet index i (never the sync value).
   function automatic logic [7:0] payload(input int i);
      logic [7:0] b;
      b = 8'(i);
      if (b == 8'h47) b = 8'h49;
      return b;
   endfunction

   // Present one byte, clock it in, settle to just after the edge.
   task automatic send(input logic [7:0] d, input logic v);
      bus.in_data  = d;
      bus.in_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic send_rest(input int from);
      for (int i = from; i < 188; i++) send(payload(i), 1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      send(8'h47, 1'b1);
      send(8'h47, 1'b1);
      checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%0b exp=0", bus.locked); end
      checks++; if (bus.mpeg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", bus.mpeg_valid); end
      checks++; if (bus.mpeg_sync !== 1'b0) begin errors++; $display("FAIL reset_sync got=%0b exp=0", bus.mpeg_sync); end
      checks++; if (bus.mpeg_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", bus.mpeg_data); end
      rst = 1'b0;
   endtask

   task automatic test_clean();
      int bad;
      for (int j = 0; j < 5; j++) send(8'h00, 1'b1);
      bad = 0;
      for (int p = 0; p < 2; p++) begin
         send(8'h47, 1'b1);
         if (bus.mpeg_valid !== 1'b0) bad++;
         for (int i = 1; i < 188; i++) begin
            send(payload(i), 1'b1);
            if (bus.mpeg_valid !== 1'b0) bad++;
         end
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL clean_no_emit_verify got=%0d exp=0", bad); end
      checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL clean_early_lock got=%0b exp=0", bus.locked); end
      send(8'h47, 1'b1);
      checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL clean_lock got=%0b exp=1", bus.locked); end
      checks++; if ({bus.mpeg_valid, bus.mpeg_sync, bus.mpeg_data} !== {2'b11, 8'h47}) begin
         errors++; $display("FAIL clean_first_sync got=%b/%b/%h exp=1/1/47", bus.mpeg_valid, bus.mpeg_sync, bus.mpeg_data); end
      bad = 0;
      for (int i = 1; i < 188; i++) begin
         send(payload(i), 1'b1);
         if (bus.mpeg_valid !== 1'b1 || bus.mpeg_sync !== 1'b0 || bus.mpeg_data !== payload(i)) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL clean_stream got=%0d exp=0", bad); end
      send(8'h47, 1'b1);
      checks++; if ({bus.mpeg_valid, bus.mpeg_sync, bus.mpeg_data} !== {2'b11, 8'h47}) begin
         errors++; $display("FAIL clean_second_sync got=%b/%b/%h exp=1/1/47", bus.mpeg_valid, bus.mpeg_sync, bus.mpeg_data); end
`ifdef TS_SYNC_STATS_EN
      checks++; if (packet_count !== 32'd2) begin errors++; $display("FAIL clean_pkt_count got=%0d exp=2", packet_count); end
`endif
      send_rest(1);
   endtask

   task automatic test_flywheel();
      for (int k = 0; k < 2; k++) begin
         send(8'h00, 1'b1);
         checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL fly_locked_%0d got=%0b exp=1", k, bus.locked); end
         checks++; if ({bus.mpeg_valid, bus.mpeg_sync, bus.mpeg_data} !== {2'b11, 8'h00}) begin
            errors++; $display("FAIL fly_sync_%0d got=%b/%b/%h exp=1/1/00", k, bus.mpeg_valid, bus.mpeg_sync, bus.mpeg_data); end
         send_rest(1);
      end
      send(8'h47, 1'b1);
      checks++; if ({bus.mpeg_valid, bus.mpeg_sync, bus.mpeg_data} !== {2'b11, 8'h47}) begin
         errors++; $display("FAIL fly_recover got=%b/%b/%h exp=1/1/47", bus.mpeg_valid, bus.mpeg_sync, bus.mpeg_data); end
      send_rest(1);
      // Two more misses must not unlock once the good sync cleared the count.
      for (int k = 0; k < 2; k++) begin
         send(8'h00, 1'b1);
         if (k == 1) begin
            checks++; if (bus.locked !== 1'b1 || bus.mpeg_valid !== 1'b1) begin
               errors++; $display("FAIL fly_miss_cleared got=%b/%b exp=1/1", bus.locked, bus.mpeg_valid); end
         end
         send_rest(1);
      end
      send(8'h47, 1'b1);
      send_rest(1);
   endtask

   task automatic test_lock_loss();
      int bad;
      for (int k = 0; k < 2; k++) begin
         send(8'h00, 1'b1);
         send_rest(1);
      end
      send(8'h00, 1'b1);
      checks++; if (bus.mpeg_valid !== 1'b0) begin errors++; $display("FAIL loss_not_emitted got=%0b exp=0", bus.mpeg_valid); end
      checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL loss_unlocked got=%0b exp=0", bus.locked); end
`ifdef TS_SYNC_STATS_EN
      checks++; if (lock_loss_count !== 32'd1) begin errors++; $display("FAIL loss_count got=%0d exp=1", lock_loss_count); end
`endif
      bad = 0;
      for (int i = 1; i < 188; i++) begin
         send(payload(i), 1'b1);
         if (bus.mpeg_valid !== 1'b0) bad++;
      end
      for (int p = 0; p < 2; p++) begin
         send(8'h47, 1'b1);
         if (bus.mpeg_valid !== 1'b0) bad++;
         for (int i = 1; i < 188; i++) begin
            send(payload(i), 1'b1);
            if (bus.mpeg_valid !== 1'b0) bad++;
         end
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL loss_quiet got=%0d exp=0", bad); end
      send(8'h47, 1'b1);
      checks++; if (bus.locked !== 1'b1 || bus.mpeg_sync !== 1'b1) begin
         errors++; $display("FAIL loss_relock got=%b/%b exp=1/1", bus.locked, bus.mpeg_sync); end
      send_rest(1);
   endtask

   task automatic test_false_sync();
      rst = 1'b1;
      send(8'h00, 1'b1);
      rst = 1'b0;
      for (int j = 0; j < 50; j++) send((j == 10) ? 8'h47 : 8'h00, 1'b1);
      for (int p = 0; p < 4; p++) begin
         send(8'h47, 1'b1);
         if (p == 2) begin
            checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL false_early_lock got=%0b exp=0", bus.locked); end
         end
         if (p == 3) begin
            checks++; if ({bus.locked, bus.mpeg_sync, bus.mpeg_data} !== {2'b11, 8'h47}) begin
               errors++; $display("FAIL false_lock got=%b/%b/%h exp=1/1/47", bus.locked, bus.mpeg_sync, bus.mpeg_data); end
            send(payload(1), 1'b1);
            checks++; if ({bus.mpeg_valid, bus.mpeg_sync, bus.mpeg_data} !== {2'b10, payload(1)}) begin
               errors++; $display("FAIL false_align got=%b/%b/%h exp=1/0/%h", bus.mpeg_valid, bus.mpeg_sync, bus.mpeg_data, payload(1)); end
            send_rest(2);
         end else begin
            send_rest(1);
         end
      end
   endtask

   task automatic test_gappy();
      int bad;
      rst = 1'b1;
      send(8'h00, 1'b1);
      rst = 1'b0;
      bad = 0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < 188; i++) begin
            send((i == 0) ? 8'h47 : payload(i), 1'b1);
            if (bus.mpeg_valid !== 1'b0) bad++;
            send(8'h47, 1'b0);
            if (bus.mpeg_valid !== 1'b0) bad++;
         end
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL gap_quiet got=%0d exp=0", bad); end
      send(8'h47, 1'b1);
      checks++; if ({bus.locked, bus.mpeg_valid, bus.mpeg_sync} !== 3'b111) begin
         errors++; $display("FAIL gap_lock got=%b exp=111", {bus.locked, bus.mpeg_valid, bus.mpeg_sync}); end
      send(8'h00, 1'b0);
      checks++; if ({bus.locked, bus.mpeg_valid, bus.mpeg_data} !== {2'b10, 8'h47}) begin
         errors++; $display("FAIL gap_idle_hold got=%b/%b/%h exp=1/0/47", bus.locked, bus.mpeg_valid, bus.mpeg_data); end
      bad = 0;
      for (int i = 1; i < 188; i++) begin
         send(payload(i), 1'b1);
         if (bus.mpeg_valid !== 1'b1 || bus.mpeg_sync !== 1'b0 || bus.mpeg_data !== payload(i)) bad++;
         send(8'h47, 1'b0);
         if (bus.mpeg_valid !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL gap_stream got=%0d exp=0", bad); end
      send(8'h47, 1'b1);
      checks++; if ({bus.mpeg_valid, bus.mpeg_sync, bus.mpeg_data} !== {2'b11, 8'h47}) begin
         errors++; $display("FAIL gap_next_sync got=%b/%b/%h exp=1/1/47", bus.mpeg_valid, bus.mpeg_sync, bus.mpeg_data); end
      send_rest(1);
   endtask

   task automatic test_reset_mid();
      int bad;
      send(8'h47, 1'b1);
      for (int i = 1; i < 90; i++) send(payload(i), 1'b1);
      rst = 1'b1;
      send(payload(90), 1'b1);
      rst = 1'b0;
      checks++; if ({bus.locked, bus.mpeg_valid, bus.mpeg_sync, bus.mpeg_data} !== 11'd0) begin
         errors++; $display("FAIL midrst_outputs got=%b/%b/%b/%h exp=0/0/0/00", bus.locked, bus.mpeg_valid, bus.mpeg_sync, bus.mpeg_data); end
`ifdef TS_SYNC_STATS_EN
      checks++; if (packet_count !== 32'd0 || lock_loss_count !== 32'd0) begin
         errors++; $display("FAIL midrst_stats got=%0d/%0d exp=0/0", packet_count, lock_loss_count); end
`endif
      bad = 0;
      for (int i = 91; i < 188; i++) begin
         send(payload(i), 1'b1);
         if (bus.mpeg_valid !== 1'b0 || bus.locked !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL midrst_quiet got=%0d exp=0", bad); end
      for (int p = 0; p < 2; p++) begin
         send(8'h47, 1'b1);
         send_rest(1);
      end
      send(8'h47, 1'b1);
      checks++; if ({bus.locked, bus.mpeg_sync, bus.mpeg_data} !== {2'b11, 8'h47}) begin
         errors++; $display("FAIL midrst_relock got=%b/%b/%h exp=1/1/47", bus.locked, bus.mpeg_sync, bus.mpeg_data); end
      send_rest(1);
   endtask

   initial begin
      errors       = 0;
      checks       = 0;
      rst          = 1'b1;
      bus.in_data  = 8'h00;
      bus.in_valid = 1'b0;
      test_reset();
      test_clean();
      test_flywheel();
      test_lock_loss();
      test_false_sync();
      test_gappy();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
